// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch-queue defaults, NOP encoding and operation decode
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_WIDTH = 32;

  // NOP bubble is all zeros; replicate to any field width.
  localparam logic FQ_NOP_BIT = 1'b0;

  typedef enum logic [2:0] {
    FQ_IDLE,
    FQ_PUSH,
    FQ_POP,
    FQ_PUSH_POP,
    FQ_FLUSH
  } fq_op_e;

  function automatic fq_op_e fq_decode(input logic flush, input logic push_ok, input logic pop_ok);
    if (flush) return FQ_FLUSH;
    case ({push_ok, pop_ok})
      2'b10:   return FQ_PUSH;
      2'b01:   return FQ_POP;
      2'b11:   return FQ_PUSH_POP;
      default: return FQ_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode side signals of the fetch queue
interface fetch_queue_if #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH,
  parameter int WIDTH = fetch_queue_pkg::FQ_WIDTH
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_pc;
  logic [WIDTH-1:0]         in_instr;
  logic                     flush;
  logic                     freeze;
  logic                     out_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_pc;
  logic [WIDTH-1:0]         out_instr;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  freeze, out_valid, out_pc, out_instr, level
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output freeze, out_valid, out_pc, out_instr, level
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - queue storage: one write port, one asynchronous read port
module fetch_queue_mem #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH,
  parameter int DW    = 2 * fetch_queue_pkg::FQ_WIDTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);
  // Contents are never observed while the queue is empty, so no reset here.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue between fetch and decode, fall-through head
module fetch_queue #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH,
  parameter int WIDTH = fetch_queue_pkg::FQ_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  q
);
  import fetch_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full, empty, push_ok, pop_ok, we;
  logic [2*WIDTH-1:0] rd_data;
  fq_op_e             op;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A pop in the same cycle never frees a slot for the incoming word.
  assign push_ok = q.in_valid && !full;
  assign pop_ok  = q.out_ready && !empty;
  assign op      = fq_decode(q.flush, push_ok, pop_ok);
  assign we      = (op == FQ_PUSH) || (op == FQ_PUSH_POP);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      FQ_FLUSH: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      FQ_PUSH: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end
      FQ_POP: begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - CW'(1);
      end
      FQ_PUSH_POP: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({q.in_pc, q.in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign q.freeze    = full;
  assign q.out_valid = !empty;
  assign q.level     = count_q;
  assign q.out_pc    = empty ? {WIDTH{FQ_NOP_BIT}} : rd_data[2*WIDTH-1:WIDTH];
  assign q.out_instr = empty ? {WIDTH{FQ_NOP_BIT}} : rd_data[WIDTH-1:0];
endmodule
